// File: rtl/dec_scan_seq.sv
// Channel scan sequencer driving the select/enable lines of a 4-to-16 decoder.
// Walks first..last (modulo 16) with a programmable dwell and optional blanking gap.
module dec_scan_seq #(
  parameter int unsigned DWELL_W   = 8,
  parameter int unsigned BLANK_CYC = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               cont,
  input  logic [3:0]         first,
  input  logic [3:0]         last,
  input  logic [DWELL_W-1:0] dwell,
  output logic               X,
  output logic               Y,
  output logic               Z,
  output logic               W,
  output logic               en,
  output logic               busy,
  output logic               done,
  output logic               wrap
);

  localparam int unsigned BW         = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam int unsigned BLANK_LAST = (BLANK_CYC > 0) ? BLANK_CYC - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DWELL = 2'd1,
    S_BLANK = 2'd2
  } state_t;

  // Where a channel change goes: through a blanking gap unless it is disabled.
  localparam state_t S_ADV = (BLANK_CYC == 0) ? S_DWELL : S_BLANK;

  state_t             state_q, state_d;
  logic [3:0]         idx_q, idx_d;
  logic [3:0]         first_q, first_d;
  logic [3:0]         last_q, last_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               cont_q, cont_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [BW-1:0]      bcnt_q, bcnt_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               wrap_q, wrap_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    first_d = first_q;
    last_d  = last_q;
    dwell_d = dwell_q;
    cont_d  = cont_q;
    cnt_d   = cnt_q;
    bcnt_d  = bcnt_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          first_d = first;
          last_d  = last;
          dwell_d = dwell;
          cont_d  = cont;
          idx_d   = first;
          cnt_d   = '0;
          state_d = S_DWELL;
        end
      end
      S_DWELL: begin
        if (cnt_q == dwell_q) begin
          cnt_d  = '0;
          bcnt_d = '0;
          if (idx_q != last_q) begin
            idx_d   = idx_q + 4'd1;
            state_d = S_ADV;
          end else if (cont_q) begin
            idx_d   = first_q;
            wrap_d  = 1'b1;
            state_d = S_ADV;
          end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + DWELL_W'(1);
        end
      end
      S_BLANK: begin
        if (bcnt_q == BW'(BLANK_LAST)) begin
          state_d = S_DWELL;
        end else begin
          bcnt_d = bcnt_q + BW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over start capture and terminal transitions; index stays put.
    if (stop) begin
      state_d = S_IDLE;
      idx_d   = idx_q;
      first_d = first_q;
      last_d  = last_q;
      dwell_d = dwell_q;
      cont_d  = cont_q;
      done_d  = 1'b0;
      wrap_d  = 1'b0;
    end

    en_d   = (state_d == S_DWELL);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      first_q <= '0;
      last_q  <= '0;
      dwell_q <= '0;
      cont_q  <= 1'b0;
      cnt_q   <= '0;
      bcnt_q  <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      first_q <= first_d;
      last_q  <= last_d;
      dwell_q <= dwell_d;
      cont_q  <= cont_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  assign {W, X, Y, Z} = idx_q;
  assign en           = en_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign wrap         = wrap_q;

endmodule

// File: tb/tb_dec_scan_seq.sv
// Directed bench for dec_scan_seq: one instance with blanking, one without.
module tb_dec_scan_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, start0, stop, cont;
  logic [3:0] first, last;
  logic [7:0] dwell;

  logic X, Y, Z, W, en, busy, done, wrap;
  logic X0, Y0, Z0, W0, en0, busy0, done0, wrap0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dec_scan_seq #(.DWELL_W(8), .BLANK_CYC(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .cont(cont),
    .first(first), .last(last), .dwell(dwell),
    .X(X), .Y(Y), .Z(Z), .W(W), .en(en), .busy(busy), .done(done), .wrap(wrap)
  );

  dec_scan_seq #(.DWELL_W(8), .BLANK_CYC(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .stop(stop), .cont(cont),
    .first(first), .last(last), .dwell(dwell),
    .X(X0), .Y(Y0), .Z(Z0), .W(W0), .en(en0), .busy(busy0), .done(done0), .wrap(wrap0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected (index, en) per cycle for a one-pass 0..3 scan, dwell=1, one blank cycle.
  int seq_idx[11] = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3};
  int seq_en[11]  = '{1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1};
  // Continuous 14..1 scan, dwell=0: two full passes.
  int cs_idx[16] = '{14, 15, 15, 0, 0, 1, 1, 14, 14, 15, 15, 0, 0, 1, 1, 14};
  int cs_en[16]  = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0};

  initial begin
    rst = 1'b1; start = 1'b0; start0 = 1'b0; stop = 1'b0; cont = 1'b0;
    first = 4'd0; last = 4'd0; dwell = 8'd0;
    #2;
    chk("rst_idx", 32'({W, X, Y, Z}), 32'd0);
    chk("rst_en_busy", 32'({en, busy, done, wrap}), 32'd0);
    step();
    step();
    rst = 1'b0;
    step();
    chk("idle_busy", 32'(busy), 32'd0);

    // One pass 0..3 with blanking
    first = 4'd0; last = 4'd3; dwell = 8'd1; cont = 1'b0; start = 1'b1;
    for (int k = 0; k < 11; k++) begin
      step();
      start = 1'b0;
      chk($sformatf("pass_idx[%0d]", k), 32'({W, X, Y, Z}), 32'(seq_idx[k]));
      chk($sformatf("pass_en[%0d]", k), 32'(en), 32'(seq_en[k]));
      chk($sformatf("pass_busy[%0d]", k), 32'({busy, done, wrap}), 32'b100);
    end
    step();
    chk("pass_done", 32'({en, busy, done, wrap}), 32'b0010);
    chk("pass_hold_idx", 32'({W, X, Y, Z}), 32'd3);
    step();
    chk("pass_done_pulse", 32'(done), 32'd0);

    // Continuous 14..1; a start with different params mid-scan must be ignored
    first = 4'd14; last = 4'd1; dwell = 8'd0; cont = 1'b1; start = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step();
      start = 1'b0;
      if (k == 2) begin
        first = 4'd3; last = 4'd9; dwell = 8'd5; start = 1'b1;
      end
      chk($sformatf("cont_idx[%0d]", k), 32'({W, X, Y, Z}), 32'(cs_idx[k]));
      chk($sformatf("cont_en[%0d]", k), 32'(en), 32'(cs_en[k]));
      chk($sformatf("cont_wrap[%0d]", k), 32'({wrap, done}),
          (k == 7 || k == 15) ? 32'b10 : 32'b00);
    end
    start = 1'b0;
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("cont_stop", 32'({en, busy, done, wrap}), 32'd0);
    chk("cont_stop_idx", 32'({W, X, Y, Z}), 32'd14);

    // Stop during the 2nd (final) dwell cycle of channel 2
    first = 4'd0; last = 4'd3; dwell = 8'd1; cont = 1'b0; start = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      start = 1'b0;
    end
    chk("stop_pre_idx", 32'({W, X, Y, Z}), 32'd2);
    chk("stop_pre_en", 32'(en), 32'd1);
    stop = 1'b1;
    step();
    chk("stop_out", 32'({en, busy, done, wrap}), 32'd0);
    chk("stop_idx", 32'({W, X, Y, Z}), 32'd2);
    start = 1'b1;
    step();
    chk("stop_over_start", 32'({en, busy}), 32'd0);
    stop = 1'b0; start = 1'b0;

    // Asynchronous reset mid-dwell
    first = 4'd5; last = 4'd7; dwell = 8'd3; start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("arst_pre", 32'({W, X, Y, Z, en, busy}), 32'b010111);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_now_idx", 32'({W, X, Y, Z}), 32'd0);
    chk("arst_now_out", 32'({en, busy, done, wrap}), 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("arst_no_done", 32'({busy, done}), 32'd0);
    first = 4'd9; last = 4'd9; dwell = 8'd0; start = 1'b1;
    step();
    start = 1'b0;
    chk("arst_restart", 32'({W, X, Y, Z, en, busy}), 32'b100111);
    step();
    chk("arst_restart_done", 32'({en, busy, done}), 32'b001);

    // Single channel, no blanking instance
    first = 4'd5; last = 4'd5; dwell = 8'd3; cont = 1'b0; start0 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      start0 = 1'b0;
      chk($sformatf("single_sel[%0d]", k), 32'({W0, X0, Y0, Z0}), 32'b0101);
      chk($sformatf("single_en[%0d]", k), 32'({en0, busy0, done0}), 32'b110);
    end
    step();
    chk("single_done", 32'({en0, busy0, done0, wrap0}), 32'b0010);
    chk("single_hold", 32'({W0, X0, Y0, Z0}), 32'b0101);
    step();
    chk("single_done_pulse", 32'(done0), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dec_scan_seq.md
DEC_SCAN_SEQ -- requirements
Module: dec_scan_seq

Interface
REQ-001 SHALL have parameter DWELL_W, default 8: width of the dwell-count input.
REQ-002 SHALL have parameter BLANK_CYC, default 1: enable-off cycles between channels; 0 disables blanking.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  begin a scan when idle.
REQ-006 SHALL have port stop  input  1  abort the scan.
REQ-007 SHALL have port cont  input  1  1 = wrap continuously, 0 = one pass.
REQ-008 SHALL have port first  input  4  first channel index.
REQ-009 SHALL have port last  input  4  last channel index.
REQ-010 SHALL have port dwell  input  DWELL_W  per-channel hold cycles minus one.
REQ-011 SHALL have ports X, Y, Z, W  output  1 each  select lines for the downstream dec_4x16 (W = index[3], X = index[2], Y = index[1], Z = index[0]).
REQ-012 SHALL have port en  output  1  decoder output qualify; 1 only while a channel dwells.
REQ-013 SHALL have port busy  output  1  1 in any non-IDLE state.
REQ-014 SHALL have port done  output  1  one-cycle pulse at one-pass completion.
REQ-015 SHALL have port wrap  output  1  one-cycle pulse on each continuous-mode wrap.

Function
REQ-016 SHALL implement states IDLE, DWELL and BLANK, with all outputs registered.
REQ-017 In IDLE, start=1 and stop=0 SHALL capture first, last, dwell and cont, set index=first and clear the dwell counter; next state is DWELL.
REQ-018 In the first DWELL cycle, en=1 and busy=1 SHALL be visible on the cycle after start is sampled.
REQ-019 In DWELL, each channel SHALL hold for exactly dwell+1 cycles with en=1; dwell=0 gives 1 cycle.
REQ-020 On the final DWELL cycle with index!=last, index SHALL become (index+1) mod 16; next state is BLANK, or DWELL when BLANK_CYC=0.
REQ-021 When first>last, the scan SHALL wrap 15->0 (e.g. 14,15,0,1).
REQ-022 On the final DWELL cycle with index==last and cont=0, next state SHALL be IDLE with done=1 for one cycle; index holds at last.
REQ-023 On the final DWELL cycle with index==last and cont=1, index SHALL become first; next state is BLANK/DWELL; wrap=1 for one cycle.
REQ-024 first==last SHALL scan the single channel (repeated when cont=1).
REQ-025 In BLANK, en=0 SHALL hold for BLANK_CYC cycles with the new index already on X/Y/Z/W; next state is DWELL.
REQ-026 stop=1 in any state SHALL force IDLE next cycle with en=0 and busy=0; index holds; no done or wrap pulse.
REQ-027 stop SHALL take priority over start and over the terminal transitions.
REQ-028 start while busy=1 SHALL be ignored; captured parameters SHALL not change mid-scan.
REQ-029 done and wrap SHALL never be asserted in the same cycle.

Reset
REQ-030 rst=1 SHALL immediately force IDLE, index=0 (X=Y=Z=W=0), en=0, busy=0, done=0, wrap=0 and dwell counter=0, regardless of the clock.
REQ-031 Reset asserted mid-scan SHALL abort without a done pulse; the first start after release SHALL behave as REQ-017.

Verification
REQ-032 first=0, last=3, dwell=1, cont=0, BLANK_CYC=1: index sequence 0,0,b,1,1,b,2,2,b,3,3 (b = en=0), then done=1 for one cycle, busy=0.
REQ-033 first=14, last=1, dwell=0, cont=1: channels 14,15,0,1,14,...; wrap pulses once per pass on the 1->14 transition.
REQ-034 stop asserted during the 2nd dwell cycle of channel 2: next cycle en=0, busy=0, index=2, done=0.
REQ-035 start pulsed while busy with different first/last: the scan order is unchanged.
REQ-036 rst asserted asynchronously mid-DWELL (between edges): outputs are at reset values before the next clock edge.
REQ-037 first=last=5, dwell=3, cont=0, BLANK_CYC=0: en=1 for exactly 4 cycles, W,X,Y,Z=0,1,0,1, then done.
